// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: SCAN call scheduler that dispatches targets, waits for arrival and holds the door open
module elevator_call_scheduler #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int DWELL_CYCLES = 50,
  parameter int MOVE_TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  input  logic                  target_ready,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  door_req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  fault
);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int TW = $clog2(MOVE_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SELECT, DISPATCH, WAIT_ARRIVE, SERVICE} state_t;
  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clear_mask;
  logic [FLOOR_W-1:0]    target_q, target_d, up_fl, dn_fl;
  logic                  valid_q, valid_d, dir_q, dir_d, door_q, door_d;
  logic                  busy_q, busy_d, fault_q, fault_d;
  logic                  here_hit, up_hit, dn_hit;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  // nearest pending floor above and below the cabin, plus a call at the cabin itself
  always_comb begin
    here_hit = 1'b0;
    up_hit   = 1'b0;
    dn_hit   = 1'b0;
    up_fl    = '0;
    dn_fl    = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && FLOOR_W'(i) > cur_floor) begin
        up_hit = 1'b1;
        up_fl  = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && FLOOR_W'(i) < cur_floor) begin
        dn_hit = 1'b1;
        dn_fl  = FLOOR_W'(i);
      end
      if (pending_q[i] && FLOOR_W'(i) == cur_floor) here_hit = 1'b1;
    end
  end
  // next-state logic; a floor's call is cleared on the edge that enters SERVICE for it
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    fault_d  = fault_q;
    dwell_d  = dwell_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: state_d = |pending_q ? SELECT : IDLE;
      SELECT: begin
        if (here_hit) begin
          state_d  = SERVICE;
          target_d = cur_floor;
          dwell_d  = '0;
        end else if (dir_q ? up_hit : dn_hit) begin
          state_d  = DISPATCH;
          target_d = dir_q ? up_fl : dn_fl;
        end else if (dir_q ? dn_hit : up_hit) begin
          state_d  = DISPATCH;
          dir_d    = ~dir_q;
          target_d = dir_q ? dn_fl : up_fl;
        end else begin
          state_d  = IDLE;
        end
      end
      DISPATCH: begin
        if (target_ready) begin
          state_d = WAIT_ARRIVE;
          tmo_d   = '0;
        end
      end
      WAIT_ARRIVE: begin
        if (arrived && cur_floor == target_q) begin
          state_d = SERVICE;
          dwell_d = '0;
        end else if (tmo_q == TW'(MOVE_TIMEOUT - 1)) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
      end
      SERVICE: begin
        if (dwell_q == DW'(DWELL_CYCLES - 1)) state_d = |pending_q ? SELECT : IDLE;
        else dwell_d = dwell_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < NUM_FLOORS; i++)
      clear_mask[i] = state_d == SERVICE && state_q != SERVICE && FLOOR_W'(i) == target_d;
    pending_d = (pending_q | call_req) & ~clear_mask;
    valid_d   = state_d == DISPATCH;
    door_d    = state_d == SERVICE;
    busy_d    = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= '0;
      valid_q   <= 1'b0;
      dir_q     <= 1'b1;
      door_q    <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      dwell_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
      door_q    <= door_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
      dwell_q   <= dwell_d;
      tmo_q     <= tmo_d;
    end
  end
  assign target_floor = target_q;
  assign target_valid = valid_q;
  assign dir_up       = dir_q;
  assign door_req     = door_q;
  assign pending      = pending_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: directed checks of call collection, SCAN order, handshake, dwell and timeout
module tb_elevator_call_scheduler;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] call_req;
  logic [1:0] cur_floor;
  logic       arrived;
  logic       target_ready;
  logic [1:0] target_floor;
  logic       target_valid;
  logic       dir_up;
  logic       door_req;
  logic [3:0] pending;
  logic       busy;
  logic       fault;
  int         checks = 0;
  int         failures = 0;
  elevator_call_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .call_req     (call_req),
    .cur_floor    (cur_floor),
    .arrived      (arrived),
    .target_ready (target_ready),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir_up       (dir_up),
    .door_req     (door_req),
    .pending      (pending),
    .busy         (busy),
    .fault        (fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!target_valid && n < 300) begin
      step();
      n++;
    end
    chk("valid_seen", int'(target_valid), 1);
  endtask
  task automatic trip(input logic [1:0] t, input logic d);
    int n = 0;
    wait_valid();
    chk("trip_target", int'(target_floor), int'(t));
    chk("trip_dir", int'(dir_up), int'(d));
    step();
    chk("trip_xfer", int'(target_valid), 0);
    cur_floor = t;
    arrived = 1'b1;
    step();
    arrived = 1'b0;
    chk("trip_door", int'(door_req), 1);
    while (door_req && n < 100) begin
      step();
      n++;
    end
    chk("trip_dwell", n, 50);
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_target"}, int'(target_floor), 0);
    chk({tag, "_valid"}, int'(target_valid), 0);
    chk({tag, "_door"}, int'(door_req), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_dir"}, int'(dir_up), 1);
  endtask
  initial begin
    int n;
    int stable;
    reset_n = 1'b0;
    call_req = '0;
    cur_floor = '0;
    arrived = 1'b0;
    target_ready = 1'b1;
    #12;
    check_reset_values("rst");
    reset_n = 1'b1;
    // single call to floor 3 from floor 0
    step();
    call_req = 4'b1000;
    step();
    call_req = '0;
    chk("t1_pending", int'(pending), 8);
    chk("t1_idle", int'(busy), 0);
    step();
    chk("t1_select_busy", int'(busy), 1);
    chk("t1_select_valid", int'(target_valid), 0);
    step();
    chk("t1_valid", int'(target_valid), 1);
    chk("t1_target", int'(target_floor), 3);
    chk("t1_dir", int'(dir_up), 1);
    step();
    chk("t1_xfer", int'(target_valid), 0);
    chk("t1_wait_busy", int'(busy), 1);
    cur_floor = 2'd3;
    arrived = 1'b1;
    step();
    arrived = 1'b0;
    chk("t1_door", int'(door_req), 1);
    chk("t1_cleared", int'(pending), 0);
    n = 0;
    while (door_req && n < 100) begin
      step();
      n++;
    end
    chk("t1_dwell", n, 50);
    chk("t1_back_idle", int'(busy), 0);
    // SCAN order from floor 1 going up with calls at 0, 2, 3
    cur_floor = 2'd1;
    call_req = 4'b1101;
    step();
    call_req = '0;
    trip(2'd2, 1'b1);
    trip(2'd3, 1'b1);
    trip(2'd0, 1'b0);
    chk("t2_pending", int'(pending), 0);
    chk("t2_idle", int'(busy), 0);
    // stalled handshake: from floor 0 heading down, call at 2 flips direction
    target_ready = 1'b0;
    call_req = 4'b0100;
    step();
    call_req = '0;
    wait_valid();
    chk("t3_target", int'(target_floor), 2);
    chk("t3_dir", int'(dir_up), 1);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (target_valid && target_floor == 2'd2 && dir_up) stable++;
    end
    chk("t3_stable", stable, 10);
    target_ready = 1'b1;
    step();
    chk("t3_xfer", int'(target_valid), 0);
    // call at the served floor in the entry cycle is dropped, a later one is kept
    cur_floor = 2'd2;
    arrived = 1'b1;
    call_req = 4'b0100;
    step();
    arrived = 1'b0;
    call_req = '0;
    chk("t4_door", int'(door_req), 1);
    chk("t4_dropped", int'(pending), 0);
    repeat (4) step();
    call_req = 4'b0100;
    step();
    call_req = '0;
    chk("t4_kept", int'(pending), 4);
    n = 0;
    while (door_req && n < 100) begin
      step();
      n++;
    end
    chk("t4_dwell", n, 45);
    chk("t4_select", int'(busy), 1);
    step();
    chk("t4_reserve_door", int'(door_req), 1);
    chk("t4_reserve_clear", int'(pending), 0);
    chk("t4_no_dispatch", int'(target_valid), 0);
    chk("t4_reserve_target", int'(target_floor), 2);
    n = 0;
    while (door_req && n < 100) begin
      step();
      n++;
    end
    chk("t4_redwell", n, 50);
    chk("t4_idle", int'(busy), 0);
    // move timeout: target floor 0 from floor 2, no arrival
    call_req = 4'b0001;
    step();
    call_req = '0;
    wait_valid();
    chk("t5_target", int'(target_floor), 0);
    chk("t5_dir", int'(dir_up), 0);
    step();
    chk("t5_xfer", int'(target_valid), 0);
    n = 0;
    while (!fault && n < 300) begin
      step();
      n++;
    end
    chk("t5_timeout_cycles", n, 200);
    chk("t5_idle", int'(busy), 0);
    chk("t5_pending", int'(pending), 1);
    wait_valid();
    step();
    repeat (5) step();
    chk("t5_sticky", int'(fault), 1);
    chk("t5_waiting", int'(busy), 1);
    // asynchronous reset in the middle of WAIT_ARRIVE
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");
    #20;
    reset_n = 1'b1;
    step();
    chk("post_rst_fault", int'(fault), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Collects floor call requests and chooses the next target floor using a direction-preserving SCAN policy.
- Hands each target to the motion controller through a valid/ready handshake, then waits for arrival.
- Holds the door-open request for a fixed dwell time before scheduling again.
- Sits between the call-button inputs and the elevator motion/door controller, and sequences that controller.

Parameters:
- NUM_FLOORS, 4, number of floors served; width of the call and pending vectors.
- FLOOR_W, 2, width of floor indices; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- DWELL_CYCLES, 50, number of cycles door_req is held high at a served floor.
- MOVE_TIMEOUT, 200, maximum cycles from dispatch to arrival before a fault is declared.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- call_req  in  NUM_FLOORS  one-cycle (or level) call per floor; bit i means a call at floor i.
- cur_floor  in  FLOOR_W  current cabin floor reported by the motion controller.
- arrived  in  1  one-cycle pulse: cabin has stopped at the dispatched target.
- target_ready  in  1  motion controller accepts target_floor.
- target_floor  out  FLOOR_W  floor being dispatched; registered.
- target_valid  out  1  target_floor is valid for handshake.
- dir_up  out  1  current scan direction: 1 = up, 0 = down.
- door_req  out  1  door-open request to the door logic.
- pending  out  NUM_FLOORS  registered outstanding calls.
- busy  out  1  high in every state except IDLE.
- fault  out  1  sticky move-timeout flag.

Behaviour:
- Reset (reset_n low, asynchronous) forces these values:
  - state = IDLE; pending = 0; target_floor = 0.
  - target_valid = 0; door_req = 0; busy = 0; fault = 0.
  - dir_up = 1; dwell and timeout counters = 0.
- Reset mid-operation drops all pending calls and any in-flight dispatch.
- pending update, every cycle: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask is the one-hot of the served floor, asserted only in the cycle SERVICE is entered.
  - A call to that same floor in that same cycle is dropped: clear wins.
- A call at cycle n appears in pending at n+1.
- FSM states: IDLE, SELECT, DISPATCH, WAIT_ARRIVE, SERVICE.
- IDLE:
  - If pending != 0, go to SELECT on the next edge.
  - Otherwise stay. Outputs are quiet.
- SELECT (one cycle), priority order:
  - (a) pending[cur_floor] set: go to SERVICE with target_floor = cur_floor; no dispatch.
  - (b) A call exists strictly in the dir_up direction: target the nearest such floor; go to DISPATCH.
  - (c) A call exists only in the opposite direction: toggle dir_up, target the nearest floor that way; go to DISPATCH.
  - (d) None of the above (calls cleared in between): go back to IDLE.
- DISPATCH:
  - target_valid = 1. target_floor and dir_up are held stable until target_valid & target_ready are both high on an edge.
  - On that transfer: target_valid = 0, timeout counter cleared, go to WAIT_ARRIVE.
  - target_ready seen while already high on entry gives a one-cycle handshake.
- WAIT_ARRIVE:
  - The timeout counter increments each cycle.
  - arrived with cur_floor == target_floor: go to SERVICE.
  - arrived with cur_floor != target_floor: ignored; keep waiting.
  - Counter reaches MOVE_TIMEOUT-1 without a valid arrival: fault = 1 (sticky until reset), go to IDLE. pending is left intact.
  - No re-targeting: a new closer call only waits in pending.
- SERVICE:
  - On entry, clear pending[target_floor].
  - door_req = 1 for exactly DWELL_CYCLES cycles (dwell counter from 0 to DWELL_CYCLES-1).
  - Then door_req = 0; go to SELECT if pending != 0, otherwise IDLE.
  - A call at the served floor arriving during dwell, after the entry cycle, is kept and served again on the next SELECT.
- Nearest-floor search is combinational over pending. Indices at or above NUM_FLOORS never match.
- Wrap-around:
  - Scan never wraps; the direction flips only at SELECT rule (c).
  - Counters saturate only through the state exit; they never overflow.
- Latency: call_req at cycle n gives SELECT at n+2 and target_valid at n+3 (only when IDLE at n).

Test Plan:
- Idle at floor 0, call_req = 4'b1000 pulse at cycle 0 -> target_valid at cycle 3 with target_floor = 3, dir_up = 1; target_ready held 1 -> transfer in one cycle; arrived with cur_floor = 3 -> door_req high for exactly 50 cycles, pending = 0, return to IDLE.
- At floor 1 moving up with pending = {0, 2, 3} -> serve order 2, 3, then dir_up toggles to 0 and floor 0 is served; the dispatched order is 2, 3, 0.
- target_ready held low for 10 cycles during DISPATCH -> target_floor, target_valid and dir_up stay constant; transfer occurs on the first ready cycle.
- call_req for floor 2 in the SERVICE entry cycle at floor 2 -> the call is dropped; the same call 5 cycles later -> pending[2] = 1 and floor 2 is re-served after dwell.
- No arrived pulse for 200 cycles after dispatch -> fault = 1, state IDLE, pending still holds the target bit; fault stays 1 until reset_n is asserted.
- reset_n asserted low during WAIT_ARRIVE -> all outputs return to reset values immediately, without waiting for a clock edge.
